// File: rtl/data_axi_bridge_pkg.sv
// Shared constants for the data-side SRAM-to-AXI3 bridge.
// An instruction-side (read-only) bridge can import the same package.
package data_axi_bridge_pkg;

  typedef enum logic [2:0] {
    BR_IDLE    = 3'd0,
    BR_RD_ADDR = 3'd1,
    BR_RD_DATA = 3'd2,
    BR_WR_REQ  = 3'd3,
    BR_WR_RESP = 3'd4,
    BR_DONE    = 3'd5
  } br_state_e;

  localparam logic [2:0] AXI_SIZE_BYTE  = 3'b000;
  localparam logic [2:0] AXI_SIZE_HALF  = 3'b001;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  // Core size code to AXI size code; the unused code 3 maps to a word.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    case (size)
      2'd0:    axi_size = AXI_SIZE_BYTE;
      2'd1:    axi_size = AXI_SIZE_HALF;
      default: axi_size = AXI_SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/data_axi_bridge_if.sv
// AXI3 channel bundle between the data bridge (master) and the crossbar (slave).
interface data_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // read address
  logic [3:0]          arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  // read data
  logic [3:0]          rid;
  logic [DATA_W-1:0]   rdata_axi;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  // write address
  logic [3:0]          awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  // write data
  logic [3:0]          wid;
  logic [DATA_W-1:0]   wdata_axi;
  logic [DATA_W/8-1:0] wstrb_axi;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  // write response
  logic [3:0]          bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata_axi, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata_axi, wstrb_axi, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata_axi, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata_axi, wstrb_axi, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/data_axi_bridge.sv
// Data-side bridge: turns one SRAM-like request into a single-beat AXI3
// read or write, one transaction outstanding at a time.
module data_axi_bridge
  import data_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                wr,
  input  logic [1:0]          size,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   wdata,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [DATA_W-1:0]   rdata,
  data_axi_bridge_if.master   axi
);

  br_state_e           state, next_state;
  logic [1:0]          lat_size;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W/8-1:0] lat_wstrb;
  logic [DATA_W-1:0]   lat_wdata;
  logic                aw_done, w_done;
  logic                aw_hs, w_hs;

  // Response IDs/codes and rlast carry nothing this single-beat bridge acts on.
  logic unused_ok;
  assign unused_ok = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

  assign aw_hs = axi.awvalid & axi.awready;
  assign w_hs  = axi.wvalid  & axi.wready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= BR_IDLE;
    else     state <= next_state;
  end

  // Request latch, write-channel completion flags and read-data capture.
  // Direction is not latched: the state itself records read vs write.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wstrb <= '0;
      lat_wdata <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rdata     <= '0;
    end else begin
      if (addr_ok) begin
        lat_size  <= size;
        lat_addr  <= addr;
        lat_wstrb <= wstrb;
        lat_wdata <= wdata;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end else if (state == BR_WR_REQ) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (state == BR_RD_DATA && axi.rvalid) rdata <= axi.rdata_axi;
    end
  end

  // Next-state logic; AW and W may finish in either order or together.
  always_comb begin
    next_state = state;
    case (state)
      BR_IDLE:    if (addr_ok) next_state = wr ? BR_WR_REQ : BR_RD_ADDR;
      BR_RD_ADDR: if (axi.arready) next_state = BR_RD_DATA;
      BR_RD_DATA: if (axi.rvalid) next_state = BR_DONE;
      BR_WR_REQ:  if ((aw_done | aw_hs) & (w_done | w_hs)) next_state = BR_WR_RESP;
      BR_WR_RESP: if (axi.bvalid) next_state = BR_DONE;
      BR_DONE:    next_state = BR_IDLE;
      default:    next_state = BR_IDLE;
    endcase
  end

  // Outputs decoded from state; payloads come from the latched request so
  // they stay stable while a valid waits for its ready.
  always_comb begin
    addr_ok       = req & ~rst & (state == BR_IDLE);
    data_ok       = (state == BR_DONE);
    axi.arid      = AXI_ID;
    axi.araddr    = lat_addr;
    axi.arlen     = AXI_LEN_SINGLE;
    axi.arsize    = axi_size(lat_size);
    axi.arburst   = AXI_BURST_INCR;
    axi.arvalid   = (state == BR_RD_ADDR);
    axi.rready    = (state == BR_RD_DATA);
    axi.awid      = AXI_ID;
    axi.awaddr    = lat_addr;
    axi.awlen     = AXI_LEN_SINGLE;
    axi.awsize    = axi_size(lat_size);
    axi.awburst   = AXI_BURST_INCR;
    axi.awvalid   = (state == BR_WR_REQ) & ~aw_done;
    axi.wid       = AXI_ID;
    axi.wdata_axi = lat_wdata;
    axi.wstrb_axi = lat_wstrb;
    axi.wlast     = 1'b1;
    axi.wvalid    = (state == BR_WR_REQ) & ~w_done;
    axi.bready    = (state == BR_WR_RESP);
  end

endmodule
